// File: rtl/rush_pkg.sv
// Shared FSM/event types, default widths and divider iteration count for rush_meter.
package rush_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_FRAC_W    = 8;
  localparam int DEF_AVG_LOG2  = 2;
  localparam int DEF_DIV_ITERS = DEF_CNT_W + DEF_FRAC_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC1,
    ST_REC2,
    ST_GAP,
    ST_DRIVE
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_START_REC,
    EV_START_REF1,
    EV_START_REF2,
    EV_END_REF1,
    EV_END_REC
  } event_e;

  // Bit 4 is start_recovery (highest priority) down to bit 0, end_recovery.
  function automatic event_e pick_event(input logic [4:0] edges);
    event_e ev;
    ev = EV_NONE;
    if (edges[4])      ev = EV_START_REC;
    else if (edges[3]) ev = EV_START_REF1;
    else if (edges[2]) ev = EV_START_REF2;
    else if (edges[1]) ev = EV_END_REF1;
    else if (edges[0]) ev = EV_END_REC;
    return ev;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done_o is high in the
// final iteration cycle and quot_o carries the finished quotient during it.
module seq_divider #(
  parameter int DVD_W = 24,
  parameter int DVS_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quot_o
);

  localparam int ITW = $clog2(DVD_W + 1);

  logic             busy_q;
  logic [ITW-1:0]   iter_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] quo_q;

  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   rem_diff;
  logic             fits;
  logic [DVS_W-1:0] rem_nxt;
  logic [DVD_W-1:0] quo_nxt;
  logic             last;

  // The dividend shifts out of quo_q's MSB while quotient bits shift into its LSB.
  always_comb begin
    rem_sh   = {rem_q, quo_q[DVD_W-1]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    fits     = (rem_sh >= {1'b0, dvs_q});
    rem_nxt  = fits ? rem_diff[DVS_W-1:0] : rem_sh[DVS_W-1:0];
    quo_nxt  = {quo_q[DVD_W-2:0], fits};
  end

  assign last = busy_q && (iter_q == ITW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      iter_q <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      iter_q <= ITW'(DVD_W);
    end else if (busy_q) begin
      iter_q <= iter_q - ITW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i && !busy_q) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last;
  assign quot_o = quo_nxt;

endmodule

// File: rtl/rush_meter.sv
// Stroke-phase timer and rush-ratio calculator. Define RUSH_AVG_EN to add a
// windowed mean of the last 2^AVG_LOG2 rush values on rush_avg.
module rush_meter
  import rush_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_recovery,
  input  logic                    start_ref1,
  input  logic                    start_ref2,
  input  logic                    end_ref1,
  input  logic                    end_recovery,
  output logic [CNT_W-1:0]        rec1_count,
  output logic [CNT_W-1:0]        rec2_count,
  output logic [CNT_W-1:0]        drive_count,
  output logic [CNT_W+FRAC_W-1:0] rush,
  output logic [CNT_W+FRAC_W-1:0] rush_avg,
  output logic                    rush_valid,
  output logic                    busy,
  output logic                    err_ovf,
  output logic                    overrun
);

  localparam int DIV_ITERS = CNT_W + FRAC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [4:0]           ev_in, ev_q, ev_edge;
  event_e               act;
  state_e               state_q, state_d;
  logic                 restart, launch, accept, ovr_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d, cnt2_q, cnt2_d, cntd_q, cntd_d;
  logic                 err_q, err_d;
  logic [CNT_W:0]       rec_sum;
  logic [CNT_W-1:0]     rec_avg;
  logic [CNT_W-1:0]     rec1_q, rec2_q, drive_q;
  logic [DIV_ITERS-1:0] rush_q, div_quot;
  logic                 rush_valid_q, ovr_q;
  logic                 div_busy, div_done;

  assign ev_in   = {start_recovery, start_ref1, start_ref2, end_ref1, end_recovery};
  assign ev_edge = ev_in & ~ev_q;
  assign act     = pick_event(ev_edge);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ev_q <= '0;
    else       ev_q <= ev_in;
  end

  // Phase FSM: only the highest-priority edge of a cycle is considered.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    launch  = 1'b0;
    case (act)
      EV_START_REC: begin
        state_d = ST_REC1;
        restart = 1'b1;
      end
      EV_START_REF1: if (state_q == ST_REC1) state_d = ST_REC2;
      EV_START_REF2: if (state_q == ST_REC2) state_d = ST_GAP;
      EV_END_REF1:   if (state_q == ST_GAP)  state_d = ST_DRIVE;
      EV_END_REC: if (state_q == ST_DRIVE) begin
        state_d = ST_IDLE;
        launch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The segment counter also counts the cycle of its closing edge.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    cntd_d = cntd_q;
    err_d  = err_q;
    if (restart) begin
      cnt1_d = '0;
      cnt2_d = '0;
      cntd_d = '0;
      err_d  = 1'b0;
    end else begin
      case (state_q)
        ST_REC1: begin
          cnt1_d = sat_inc(cnt1_q);
          err_d  = err_q | (cnt1_q == CNT_MAX);
        end
        ST_REC2: begin
          cnt2_d = sat_inc(cnt2_q);
          err_d  = err_q | (cnt2_q == CNT_MAX);
        end
        ST_DRIVE: begin
          cntd_d = sat_inc(cntd_q);
          err_d  = err_q | (cntd_q == CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      cntd_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      cntd_q <= cntd_d;
      err_q  <= err_d;
    end
  end

  assign accept  = launch && !div_busy;
  assign ovr_d   = launch && div_busy;
  assign rec_sum = {1'b0, cnt1_d} + {1'b0, cnt2_d};
  assign rec_avg = rec_sum[CNT_W:1];

  seq_divider #(
    .DVD_W(DIV_ITERS),
    .DVS_W(CNT_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept),
    .dividend_i({rec_avg, {FRAC_W{1'b0}}}),
    .divisor_i (cntd_d),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot)
  );

  // Snapshot at launch, result capture at divider completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec1_q       <= '0;
      rec2_q       <= '0;
      drive_q      <= '0;
      rush_q       <= '0;
      rush_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      if (accept) begin
        rec1_q  <= cnt1_d;
        rec2_q  <= cnt2_d;
        drive_q <= cntd_d;
      end
      if (div_done) rush_q <= div_quot;
      rush_valid_q <= div_done;
      ovr_q        <= ovr_d;
    end
  end

`ifdef RUSH_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DIV_ITERS + AVG_LOG2;

  logic [DIV_ITERS-1:0] ring_q [DEPTH];
  logic [AVG_LOG2-1:0]  wr_q;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [DIV_ITERS-1:0] avg_q;

  assign sum_d = sum_q - SUM_W'(ring_q[wr_q]) + SUM_W'(div_quot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_q  <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else if (div_done) begin
      ring_q[wr_q] <= div_quot;
      wr_q         <= wr_q + 1'b1;
      sum_q        <= sum_d;
      avg_q        <= DIV_ITERS'(sum_d >> AVG_LOG2);
    end
  end

  assign rush_avg = avg_q;
`else
  assign rush_avg = rush_q;
`endif

  assign rec1_count  = rec1_q;
  assign rec2_count  = rec2_q;
  assign drive_count = drive_q;
  assign rush        = rush_q;
  assign rush_valid  = rush_valid_q;
  assign busy        = div_busy;
  assign err_ovf     = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_rush_meter.sv
// Randomised stroke stimulus for rush_meter checked against a stroke-level model.
module tb_rush_meter;

  localparam int CNT_W    = 16;
  localparam int FRAC_W   = 8;
  localparam int AVG_LOG2 = 2;
  localparam int RW       = CNT_W + FRAC_W;
  localparam int WIN      = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_recovery = 1'b0, start_ref1 = 1'b0, start_ref2 = 1'b0;
  logic end_ref1 = 1'b0, end_recovery = 1'b0;
  logic [CNT_W-1:0] rec1_count, rec2_count, drive_count;
  logic [RW-1:0]    rush, rush_avg;
  logic             rush_valid, busy, err_ovf, overrun;

  rush_meter #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .reset(reset),
    .start_recovery(start_recovery), .start_ref1(start_ref1), .start_ref2(start_ref2),
    .end_ref1(end_ref1), .end_recovery(end_recovery),
    .rec1_count(rec1_count), .rec2_count(rec2_count), .drive_count(drive_count),
    .rush(rush), .rush_avg(rush_avg), .rush_valid(rush_valid), .busy(busy),
    .err_ovf(err_ovf), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  int     nvalid = 0;
  int     nov = 0;
  longint vcyc = 0;
  longint vrush = 0, vavg = 0, vbusy = 0;
  longint win[WIN];
  int     wcnt = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rush_valid) begin
      nvalid++;
      vcyc  = cyc;
      vrush = longint'(rush);
      vavg  = longint'(rush_avg);
      vbusy = longint'(busy);
    end
    if (overrun) nov++;
  endtask

  task automatic idle(input longint n);
    for (longint i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int sel, output longint t);
    t = cyc;
    case (sel)
      0: start_recovery = 1'b1;
      1: start_ref1     = 1'b1;
      2: start_ref2     = 1'b1;
      3: end_ref1       = 1'b1;
      default: end_recovery = 1'b1;
    endcase
    tick();
    start_recovery = 1'b0; start_ref1 = 1'b0; start_ref2 = 1'b0;
    end_ref1 = 1'b0; end_recovery = 1'b0;
  endtask

  task automatic do_stroke(input longint r1, input longint r2, input longint gap,
                           input longint d, output longint tend);
    longint t;
    pulse(0, t); idle(r1 - 1);
    pulse(1, t); idle(r2 - 1);
    pulse(2, t); idle(gap - 1);
    pulse(3, t); idle(d - 1);
    pulse(4, tend);
  endtask

  // Reference: saturated segment lengths and the fixed-point ratio from them.
  function automatic longint sat(input longint v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic longint ratio(input longint r1, input longint r2, input longint d);
    return (((sat(r1) + sat(r2)) / 2) * (1 << FRAC_W)) / sat(d);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < WIN; i++) win[i] = 0;
    wcnt = 0;
  endfunction

  // Mean over the last WIN results, with zeros standing in before WIN results exist.
  function automatic longint model_push(input longint r);
    longint s;
    win[wcnt % WIN] = r;
    wcnt++;
    s = 0;
    for (int i = 0; i < WIN; i++) s += win[i];
`ifdef RUSH_AVG_EN
    return s / WIN;
`else
    return r;
`endif
  endfunction

  task automatic check_snap(input longint r1, input longint r2, input longint d);
    check_val("rec1_count", longint'(rec1_count), sat(r1));
    check_val("rec2_count", longint'(rec2_count), sat(r2));
    check_val("drive_count", longint'(drive_count), sat(d));
    check_val("busy_after_launch", longint'(busy), 1);
  endtask

  task automatic expect_result(input longint r1, input longint r2, input longint d,
                               input longint tend, input int nv_base);
    longint er, ea;
    int guard;
    guard = 0;
    er = ratio(r1, r2, d);
    while (nvalid == nv_base && guard < 60) begin
      tick();
      guard++;
    end
    check_val("rush_valid_seen", nvalid - nv_base, 1);
    check_val("rush_latency", vcyc - tend, 25);
    check_val("rush", vrush, er);
    ea = model_push(er);
    check_val("rush_avg", vavg, ea);
    check_val("busy_at_valid", vbusy, 0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rec1"}, longint'(rec1_count), 0);
    check_val({tag, "_drive"}, longint'(drive_count), 0);
    check_val({tag, "_rush"}, longint'(rush), 0);
    check_val({tag, "_rush_avg"}, longint'(rush_avg), 0);
    check_val({tag, "_flags"}, longint'({rush_valid, busy, err_ovf, overrun}), 0);
  endtask

  initial begin
    longint t, t1, t2;
    int nv0, nov0;
    longint r1, r2, gp, d;

    model_clear();
    idle(3);
    check_zero("reset");
    check_val("reset_rec2", longint'(rec2_count), 0);
    reset = 1'b0;
    idle(2);

    // Nominal stroke four times: rush 2.0, average ramps up from zero.
    for (int k = 0; k < 4; k++) begin
      nv0 = nvalid;
      do_stroke(40, 60, 10, 25, t);
      check_snap(40, 60, 25);
      expect_result(40, 60, 25, t, nv0);
      idle(3);
    end

    // A start_ref2 edge inside REC1 is ignored.
    nv0 = nvalid;
    pulse(0, t); idle(9);
    pulse(2, t); idle(19);
    pulse(1, t); idle(69);
    pulse(2, t); idle(4);
    pulse(3, t); idle(19);
    pulse(4, t);
    check_snap(30, 70, 20);
    expect_result(30, 70, 20, t, nv0);
    idle(2);

    // Second stroke ends while the divider is still busy.
    nv0 = nvalid;
    nov0 = nov;
    do_stroke(40, 60, 10, 25, t1);
    do_stroke(2, 2, 2, 3, t2);
    check_val("overrun_gap", t2 - t1, 10);
    check_val("snap_kept_rec1", longint'(rec1_count), 40);
    check_val("snap_kept_drive", longint'(drive_count), 25);
    expect_result(40, 60, 25, t1, nv0);
    idle(40);
    check_val("overrun_valid_count", nvalid - nv0, 1);
    check_val("overrun_pulses", nov - nov0, 1);

    // Saturating REC1 sets err_ovf until the next start_recovery edge.
    nv0 = nvalid;
    do_stroke(70000, 100, 3, 50, t);
    check_val("err_ovf_set", longint'(err_ovf), 1);
    check_snap(70000, 100, 50);
    expect_result(70000, 100, 50, t, nv0);
    nv0 = nvalid;
    pulse(0, t);
    check_val("err_ovf_cleared", longint'(err_ovf), 0);
    idle(19);
    pulse(1, t); idle(19);
    pulse(2, t); idle(1);
    pulse(3, t); idle(9);
    pulse(4, t);
    check_snap(20, 20, 10);
    expect_result(20, 20, 10, t, nv0);

    // Random strokes.
    for (int k = 0; k < 8; k++) begin
      r1 = $urandom_range(400, 1);
      r2 = $urandom_range(400, 1);
      gp = $urandom_range(20, 1);
      d  = $urandom_range(200, 1);
      nv0 = nvalid;
      do_stroke(r1, r2, gp, d, t);
      check_snap(r1, r2, d);
      expect_result(r1, r2, d, t, nv0);
      idle($urandom_range(5, 1));
    end

    // Reset five cycles into a division.
    do_stroke(40, 60, 10, 25, t);
    idle(4);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    model_clear();
    tick();
    reset = 1'b0;
    nv0 = nvalid;
    idle(40);
    check_val("midreset_no_valid", nvalid - nv0, 0);
    check_val("midreset_rush", longint'(rush), 0);

    // Recovery after reset.
    nv0 = nvalid;
    do_stroke(40, 60, 10, 25, t);
    check_snap(40, 60, 25);
    expect_result(40, 60, 25, t, nv0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rush_meter.md
# rush_meter

Parametrised stroke-phase timer and rush-ratio calculator for the erg datapath. It times the two recovery reference segments and the drive segment of each rowing stroke from five phase-event inputs. At stroke end it computes rush = mean(recovery segments) / drive in unsigned fixed point using a sequential divider. With `RUSH_AVG_EN` defined, it also keeps a windowed mean of recent rush values.

## Interface
- CNT_W, 16: segment counter width, in cycles.
- FRAC_W, 8: fractional bits of the rush ratio.
- AVG_LOG2, 2: log2 of the averaging window depth. Used only with `RUSH_AVG_EN`.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_recovery  in  1  phase event, level; rising edge detected internally.
- start_ref1  in  1  phase event, level; rising edge detected internally.
- start_ref2  in  1  phase event, level; rising edge detected internally.
- end_ref1  in  1  phase event, level; rising edge detected internally.
- end_recovery  in  1  phase event, level; rising edge detected internally.
- rec1_count  out  CNT_W  recovery segment 1 length of the last completed stroke.
- rec2_count  out  CNT_W  recovery segment 2 length of the last completed stroke.
- drive_count  out  CNT_W  drive segment length of the last completed stroke.
- rush  out  CNT_W+FRAC_W  ratio, unsigned, FRAC_W fractional bits.
- rush_avg  out  CNT_W+FRAC_W  windowed mean of rush.
- rush_valid  out  1  one-cycle pulse when rush and rush_avg update.
- busy  out  1  divider running.
- err_ovf  out  1  sticky flag: a segment counter saturated.
- overrun  out  1  one-cycle pulse: stroke dropped because the divider was busy.

## Operation
- Event inputs are synchronous to clk.
- edge_x = x & ~x_q, where x_q is x registered; x_q resets to 0.
- FSM states: IDLE, REC1, REC2, GAP, DRIVE. Reset state is IDLE.
- When several edges occur in one cycle, only one is acted on. Priority order: start_recovery, start_ref1, start_ref2, end_ref1, end_recovery.
- Transitions:
  - start_recovery edge from any state: go to REC1; clear all three working counters and err_ovf.
  - start_ref1 edge in REC1: go to REC2.
  - start_ref2 edge in REC2: go to GAP.
  - end_ref1 edge in GAP: go to DRIVE.
  - end_recovery edge in DRIVE: go to IDLE and launch the stroke computation.
  - Any other edge/state combination is ignored; the state is held.
- Counting: cnt1 increments each cycle in REC1, cnt2 in REC2, cntd in DRIVE. No counter runs in GAP or IDLE. A segment therefore equals the cycle distance between its bounding edges.
- Saturation: counters stop at all-ones and set err_ovf.
- Launch on end_recovery (not busy):
  - Snapshot the counters into rec1_count, rec2_count, drive_count.
  - avg = (cnt1 + cnt2) >> 1, with a CNT_W+1-bit sum.
  - Divider computes (avg << FRAC_W) / cntd. cntd is ≥1 by construction.
  - The quotient fits CNT_W+FRAC_W bits; no saturation is needed.
- Launch while busy: the stroke is discarded, overrun pulses, the FSM still goes to IDLE, and the snapshot outputs are not updated.
- Counting for the next stroke proceeds while the divider runs.
- Reset values: all outputs 0; the FSM goes to IDLE and the divider aborts.

## Timing
- Edge sampled at cycle t: the FSM changes at t+1.
- end_recovery edge at t: snapshot outputs and busy=1 at t+1.
- rush_valid=1 and rush/rush_avg updated at t+1+CNT_W+FRAC_W. busy deasserts in that same cycle.
- Divider is restoring, 1 quotient bit per cycle, CNT_W+FRAC_W iterations.
- Reset asserted mid-division: no rush_valid is produced.

## Configuration
- `RUSH_AVG_EN` defined:
  - Ring buffer of 2^AVG_LOG2 rush values plus a running sum register, all resetting to 0.
  - On each result: sum <= sum − oldest + rush_new; the oldest entry is replaced.
  - rush_avg = (updated sum) >> AVG_LOG2, registered in the rush_valid cycle.
  - The mean ramps up from zeros.
- Not defined: no buffer logic; rush_avg equals rush.

## Structure
- Package rush_pkg holds:
  - the FSM state enum;
  - default widths;
  - the divider iteration-count localparam (CNT_W+FRAC_W).
- Sub-module seq_divider, a start/busy/done unsigned restoring divider parametrised by dividend and divisor width, instantiated once.

## Test plan
All scenarios use CNT_W=16, FRAC_W=8.
- Edges at offsets 0, 40, 100, 110, 135 → rec1 40, rec2 60, drive 25, rush 512 (2.0). rush_valid exactly 25 cycles after the end_recovery edge.
- start_ref2 edge while in REC1 → ignored; state stays REC1 and cnt1 keeps counting.
- REC1 held for 70000 cycles → rec1_count 65535 and err_ovf=1. err_ovf clears on the next start_recovery edge.
- Second stroke ending 10 cycles after the first (divider busy) → overrun pulses once; no second rush_valid.
- `RUSH_AVG_EN`, AVG_LOG2=2, rush results 512, 512, 512, 512 → rush_avg 128, 256, 384, 512.
- Reset asserted 5 cycles into a division → all outputs 0; no rush_valid pulse afterwards.
